ctrl_pipe: RTL and testbench
============================

CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 Parameter STAGES, default 3, meaning number of control pipeline stages (stage 0 = EX, 1 = MEM, 2 = WB); legal range 1..8.
REQ-002 Parameter FLUSH_DEPTH, default 1, meaning number of youngest stages (incoming included) killed by flush; legal range 1..STAGES.
REQ-003 Parameter CNT_W, default 16, meaning width of the bubble counter.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 id_valid  in  1  decode stage presents a real instruction.
REQ-007 id_alu_src, id_alu_op, id_mem_write, id_mem_read, id_mem_mode, id_mem_to_reg, id_reg_write  in  1/ALUOP_WIDTH/1/1/MEM_MODE_WIDTH/1/1  decoded control fields.
REQ-008 stall  in  1  hazard detection request: inject a bubble at stage 0 this cycle.
REQ-009 flush  in  1  branch/jump redirect: kill the FLUSH_DEPTH youngest slots.
REQ-010 freeze  in  1  global hold (memory wait): no stage changes.
REQ-011 cnt_clr  in  1  synchronous clear of bubble_cnt.
REQ-012 ctrl_o  out  STAGES*CTRL_W  flattened per-stage control bundles; stage k occupies bits [k*CTRL_W +: CTRL_W].
REQ-013 valid_o  out  STAGES  per-stage valid flag.
REQ-014 bubble_cnt  out  CNT_W  saturating count of bubbles injected by stall or flush.

Function
REQ-015 Bundle packing, LSB first: reg_write[0], mem_to_reg[1], mem_mode[4:2], mem_read[5], mem_write[6], alu_op[10:7], alu_src[11]; CTRL_W = 12 for ALUOP_WIDTH 4, MEM_MODE_WIDTH 3.
REQ-016 A bubble is an all-zero bundle with valid 0 (ALU_SRC_REG, ALU_ADD, MEM_WR_DIS, MEM_RD_DIS, MEM_BYTE, MEMREG_DIS, REG_WR_DIS).
REQ-017 Priority per cycle: reset > freeze > flush > stall > normal advance.
REQ-018 Normal: stage 0 loads the id bundle and valid = id_valid; stage k>0 loads stage k-1; latency ID to stage k output = k+1 cycles.
REQ-019 id_valid = 0 (no freeze/flush/stall): stage 0 loads a bubble; not counted.
REQ-020 Stall (no freeze/flush): stage 0 loads a bubble; stages k>0 advance normally; bubble_cnt increments.
REQ-021 Flush (no freeze): stage 0 loads a bubble; each stage k with 1 <= k < FLUSH_DEPTH loads a bubble; stages k >= FLUSH_DEPTH advance normally; bubble_cnt increments once; stall in the same cycle adds no extra count.
REQ-022 Freeze: all stages and bubble_cnt hold; stall, flush and cnt_clr are ignored that cycle.
REQ-023 bubble_cnt saturates at 2^CNT_W-1; cnt_clr (not frozen) forces 0 and takes precedence over an increment in the same cycle.
REQ-024 Outputs are registered only; no combinational path from any input to ctrl_o, valid_o or bubble_cnt.
REQ-025 Stored bundle of an invalid stage is always all zero, so downstream logic needs no valid gating.

Reset
REQ-026 rst_n low asynchronously clears every stage to a bubble (ctrl_o = 0, valid_o = 0) and bubble_cnt to 0, including mid-stall or mid-flush.
REQ-027 After rst_n rises, the first rising clk edge applies the normal rules; no in-flight state survives reset.

Structure
REQ-028 CTRL_W, the field bit offsets and the bubble encoding are defined in the shared define.vh next to ALUOP_WIDTH and MEM_MODE_WIDTH.
REQ-029 One sub-module, ctrl_stage_reg (CTRL_W bundle + valid, load/bubble/hold controls, async reset), instantiated STAGES times by a generate loop.

Verification
REQ-030 Stream id_valid = 1, id_alu_op 1,2,3,4, defaults STAGES 3 -> alu_op 1 visible at stage 0 after 1 edge, stage 2 after 3 edges; valid_o = 3'b111 from the third edge onward.
REQ-031 stall for one cycle with a load at stage 0 (mem_read 1) -> next cycle valid_o = 3'b110, stage 0 bundle = 0, the load moves to stage 1 with mem_read 1, bubble_cnt = 1.
REQ-032 FLUSH_DEPTH 2, stages full, flush and stall high together -> stages 0 and 1 become bubbles, stage 2 holds the old stage-1 bundle, bubble_cnt increments by exactly 1.
REQ-033 freeze held 4 cycles while stall and flush toggle -> ctrl_o, valid_o and bubble_cnt are unchanged throughout.
REQ-034 CNT_W 2, stall held 5 cycles -> bubble_cnt 1,2,3,3,3; cnt_clr together with stall -> 0.
REQ-035 rst_n pulled low between clock edges during a stall -> ctrl_o, valid_o and bubble_cnt are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control pipeline: field widths, bundle layout,
// bubble encoding and the per-stage update command.
package ctrl_pipe_pkg;

  localparam int unsigned ALUOP_WIDTH    = 4;
  localparam int unsigned MEM_MODE_WIDTH = 3;
  localparam int unsigned CTRL_W         = 12;

  localparam int unsigned REG_WRITE_BIT  = 0;
  localparam int unsigned MEM_TO_REG_BIT = 1;
  localparam int unsigned MEM_MODE_LSB   = 2;
  localparam int unsigned MEM_READ_BIT   = 5;
  localparam int unsigned MEM_WRITE_BIT  = 6;
  localparam int unsigned ALU_OP_LSB     = 7;
  localparam int unsigned ALU_SRC_BIT    = 11;

  // Declared MSB first so the packed layout matches the bit offsets above.
  typedef struct packed {
    logic                      alu_src;
    logic [ALUOP_WIDTH-1:0]    alu_op;
    logic                      mem_write;
    logic                      mem_read;
    logic [MEM_MODE_WIDTH-1:0] mem_mode;
    logic                      mem_to_reg;
    logic                      reg_write;
  } ctrl_t;

  // ALU_SRC_REG, ALU_ADD, MEM_WR_DIS, MEM_RD_DIS, MEM_BYTE, MEMREG_DIS, REG_WR_DIS
  localparam ctrl_t CTRL_BUBBLE = '0;

  typedef enum logic [1:0] {
    STG_HOLD   = 2'd0,
    STG_LOAD   = 2'd1,
    STG_BUBBLE = 2'd2
  } stage_cmd_e;

endpackage

// File: rtl/ctrl_pipe_stage_reg.sv
// One control pipeline slot: bundle plus valid, with hold/load/bubble commands.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  stage_cmd_e cmd_i,
  input  ctrl_t      d_i,
  input  logic       d_valid_i,
  output ctrl_t      q_o,
  output logic       valid_o
);

  ctrl_t ctrl_q, ctrl_d;
  logic  valid_q, valid_d;

  always_comb begin
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    unique case (cmd_i)
      STG_LOAD: begin
        // An invalid slot always stores zeros so consumers need no gating.
        valid_d = d_valid_i;
        ctrl_d  = d_valid_i ? d_i : CTRL_BUBBLE;
      end
      STG_BUBBLE: begin
        valid_d = 1'b0;
        ctrl_d  = CTRL_BUBBLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q  <= CTRL_BUBBLE;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign q_o     = ctrl_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Control-signal pipeline EX/MEM/WB... with stall/flush bubble injection,
// global freeze and a saturating bubble counter.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int unsigned STAGES      = 3,
  parameter int unsigned FLUSH_DEPTH = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_valid,
  input  logic                      id_alu_src,
  input  logic [ALUOP_WIDTH-1:0]    id_alu_op,
  input  logic                      id_mem_write,
  input  logic                      id_mem_read,
  input  logic [MEM_MODE_WIDTH-1:0] id_mem_mode,
  input  logic                      id_mem_to_reg,
  input  logic                      id_reg_write,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      freeze,
  input  logic                      cnt_clr,
  output logic [STAGES*CTRL_W-1:0]  ctrl_o,
  output logic [STAGES-1:0]         valid_o,
  output logic [CNT_W-1:0]          bubble_cnt
);

  ctrl_t id_bundle;
  ctrl_t stage_ctrl  [STAGES];
  logic  stage_valid [STAGES];

  always_comb begin
    id_bundle            = CTRL_BUBBLE;
    id_bundle.alu_src    = id_alu_src;
    id_bundle.alu_op     = id_alu_op;
    id_bundle.mem_write  = id_mem_write;
    id_bundle.mem_read   = id_mem_read;
    id_bundle.mem_mode   = id_mem_mode;
    id_bundle.mem_to_reg = id_mem_to_reg;
    id_bundle.reg_write  = id_reg_write;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_cmd_e cmd;
    ctrl_t      d;
    logic       dv;

    if (k == 0) begin : g_src_id
      assign d  = id_bundle;
      assign dv = id_valid;
    end else begin : g_src_prev
      assign d  = stage_ctrl[k-1];
      assign dv = stage_valid[k-1];
    end

    // Priority: freeze > flush (youngest FLUSH_DEPTH slots) > stall (slot 0) > advance.
    always_comb begin
      cmd = STG_LOAD;
      if (freeze)
        cmd = STG_HOLD;
      else if (flush && (k < FLUSH_DEPTH))
        cmd = STG_BUBBLE;
      else if (stall && (k == 0))
        cmd = STG_BUBBLE;
    end

    ctrl_stage_reg u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_i     (cmd),
      .d_i       (d),
      .d_valid_i (dv),
      .q_o       (stage_ctrl[k]),
      .valid_o   (stage_valid[k])
    );

    assign ctrl_o[k*CTRL_W +: CTRL_W] = stage_ctrl[k];
    assign valid_o[k]                 = stage_valid[k];
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!freeze) begin
      if (cnt_clr)
        cnt_d = '0;
      else if ((stall || flush) && (cnt_q != '1))
        cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: queue-based pipeline model feeds expected
// outputs to an independent monitor that checks after each clock/reset event.
module tb_ctrl_pipe;

  localparam int S  = 3;
  localparam int FD = 2;
  localparam int CW = 2;
  localparam int W  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0, id_alu_src = 1'b0, id_mem_write = 1'b0, id_mem_read = 1'b0;
  logic [3:0]    id_alu_op = '0;
  logic [2:0]    id_mem_mode = '0;
  logic          id_mem_to_reg = 1'b0, id_reg_write = 1'b0;
  logic          stall = 1'b0, flush = 1'b0, freeze = 1'b0, cnt_clr = 1'b0;
  logic [S*W-1:0] ctrl_o;
  logic [S-1:0]   valid_o;
  logic [CW-1:0]  bubble_cnt;

  ctrl_pipe #(.STAGES(S), .FLUSH_DEPTH(FD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_alu_src(id_alu_src),
    .id_alu_op(id_alu_op), .id_mem_write(id_mem_write), .id_mem_read(id_mem_read),
    .id_mem_mode(id_mem_mode), .id_mem_to_reg(id_mem_to_reg), .id_reg_write(id_reg_write),
    .stall(stall), .flush(flush), .freeze(freeze), .cnt_clr(cnt_clr),
    .ctrl_o(ctrl_o), .valid_o(valid_o), .bubble_cnt(bubble_cnt)
  );

  typedef struct {
    logic [S*W-1:0] c;
    logic [S-1:0]   v;
    logic [CW-1:0]  n;
  } exp_t;

  exp_t        sb[$];
  int unsigned pipe_c[$];
  bit          pipe_v[$];
  int unsigned m_cnt;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic void model_reset();
    pipe_c.delete();
    pipe_v.delete();
    for (int i = 0; i < S; i++) begin
      pipe_c.push_back(0);
      pipe_v.push_back(1'b0);
    end
    m_cnt = 0;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.c = '0;
    e.v = '0;
    for (int k = 0; k < S; k++) begin
      e.c[k*W +: W] = W'(pipe_c[k]);
      e.v[k]        = pipe_v[k];
    end
    e.n = CW'(m_cnt);
    sb.push_back(e);
  endfunction

  task automatic cyc(input bit rstn, input bit idv, input int unsigned op,
                     input bit stl, input bit fl, input bit frz, input bit clr);
    int unsigned b;
    bit          live;
    @(negedge clk);
    rst_n         = rstn;
    id_valid      = idv;
    id_alu_op     = 4'(op);
    id_alu_src    = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_mem_read   = 1'($urandom);
    id_mem_mode   = 3'($urandom);
    id_mem_to_reg = 1'($urandom);
    id_reg_write  = 1'($urandom);
    stall         = stl;
    flush         = fl;
    freeze        = frz;
    cnt_clr       = clr;
    b = 32'(id_alu_src) * 2048 + 32'(id_alu_op) * 128 + 32'(id_mem_write) * 64
      + 32'(id_mem_read) * 32 + 32'(id_mem_mode) * 4 + 32'(id_mem_to_reg) * 2
      + 32'(id_reg_write);
    if (!rstn) begin
      model_reset();
    end else if (!frz) begin
      live = idv && !stl && !fl;
      pipe_c.push_front(live ? b : 0);
      pipe_v.push_front(live);
      void'(pipe_c.pop_back());
      void'(pipe_v.pop_back());
      if (fl) begin
        for (int i = 0; i < FD; i++) begin
          pipe_c[i] = 0;
          pipe_v[i] = 1'b0;
        end
      end
      if (clr)
        m_cnt = 0;
      else if ((stl || fl) && (m_cnt < (2**CW - 1)))
        m_cnt++;
    end
    push_exp();
  endtask

  task automatic mid_reset();
    @(posedge clk);
    #3;
    model_reset();
    push_exp();
    rst_n = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (ctrl_o !== e.c) begin
          n_bad++;
          $display("FAIL ctrl_o t=%0t got=%h exp=%h", $time, ctrl_o, e.c);
        end
        n_cmp++;
        if (valid_o !== e.v) begin
          n_bad++;
          $display("FAIL valid_o t=%0t got=%b exp=%b", $time, valid_o, e.v);
        end
        n_cmp++;
        if (bubble_cnt !== e.n) begin
          n_bad++;
          $display("FAIL bubble_cnt t=%0t got=%0d exp=%0d", $time, bubble_cnt, e.n);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    for (int unsigned op = 1; op <= 4; op++) cyc(1, 1, op, 0, 0, 0, 0);
    cyc(1, 1, 5, 0, 0, 0, 0);
    cyc(1, 1, 6, 1, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0, 0);
    cyc(1, 1, 8, 0, 0, 0, 0);
    cyc(1, 1, 9, 1, 1, 0, 0);
    cyc(1, 1, 10, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 11, i[0], i[1], 1, i[0]);
    cyc(1, 1, 12, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 1, 13, 1, 0, 0, 0);
    cyc(1, 1, 14, 1, 0, 0, 1);
    cyc(1, 0, 15, 0, 0, 0, 0);
    cyc(1, 1, 3, 1, 0, 0, 0);
    mid_reset();
    cyc(0, 1, 2, 1, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 79) == 0) begin
        mid_reset();
        cyc(0, 1'($urandom), $urandom_range(0, 15), 1'($urandom), 1'($urandom), 1'b0, 1'b0);
      end
      cyc(1, $urandom_range(0, 3) != 0, $urandom_range(0, 15),
          $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
          $urandom_range(0, 6) == 0, $urandom_range(0, 15) == 0);
    end
    @(posedge clk);
    #3;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
